reg_stack_ctrl: RTL
===================

# reg_stack_ctrl

Operand-stack controller for the stack machine: it drives the 8×8-bit register file as a LIFO of up to 8 bytes. It owns the register file's two read-select ports and its write port, and tracks stack depth. It executes one stack command per valid/ready handshake and exposes the top two entries to the datapath and ALU. It sits between instruction decode (command source) and the register file.

## Interface
Parameters: none (depth fixed at 8, width fixed at 8).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 BINOP, 7 CLEAR.
- cmd_data  in  8  PUSH operand.
- alu_result  in  8  combinational ALU result of (top_data, second_data), used by BINOP.
- top_data  out  8  stack top; equals rf_re_data_a.
- second_data  out  8  entry below top; equals rf_re_data_b.
- depth  out  4  occupied entries, 0..8.
- empty / full  out  1  depth==0 / depth==8.
- err_overflow / err_underflow  out  1  sticky error flags.
- rf_re_sel_a / rf_re_sel_b  out  3  register-file read selects.
- rf_re_data_a / rf_re_data_b  in  8  register-file read data (combinational).
- rf_wr_sel  out  3  register-file write select.
- rf_wr_data  out  8  register-file write data.
- rf_wr_en  out  1  register-file write enable.

## Operation
- Slot k holds entry k; top is slot depth-1 and second is slot depth-2, both computed mod 8 on 3 bits.
- rf_re_sel_a = depth-1 and rf_re_sel_b = depth-2, always driven. top_data and second_data are meaningful only when depth≥1 and depth≥2 respectively.
- States: IDLE, SWAP2. cmd_ready = (state==IDLE).
- A command is accepted when cmd_valid && cmd_ready. All commands other than SWAP complete in the accept cycle. Write port signals are combinational from the accepted command and state.
- PUSH: write slot depth ← cmd_data; depth+1.
- POP: no write; depth-1.
- DUP: write slot depth ← top; depth+1.
- OVER: write slot depth ← second; depth+1.
- BINOP: write slot depth-2 ← alu_result; depth-1.
- SWAP: in the accept cycle, write slot depth-2 ← top and latch second into hold register; go to SWAP2. In SWAP2, write slot depth-1 ← hold; return to IDLE. depth is unchanged.
- CLEAR: depth←0; clears both error flags; no write.
- NOP: no effect.
- Error checks are evaluated at accept:
  - underflow: POP/DUP with depth==0; SWAP/OVER/BINOP with depth<2.
  - overflow: PUSH/DUP/OVER with depth==8.
  - Underflow takes precedence when both apply.
  - An erroring command is consumed: no write, depth unchanged, no transition to SWAP2, corresponding flag set and held until CLEAR or reset.
- Accepting a command while a flag is already set behaves normally.

## Timing
- Reset (async, immediate): state IDLE, depth 0, hold 0, err flags 0. Outputs: cmd_ready 1, empty 1, full 0, rf_wr_en 0 (forced 0 while reset high), rf_re_sel_a 7, rf_re_sel_b 6. Commands presented while reset is high are ignored.
- Register-file contents are not cleared by reset; depth 0 makes them unreachable.
- Write latency: the write lands at the accept-cycle edge. top_data reflects the new top combinationally in the next cycle, with zero bubble for back-to-back commands.
- SWAP occupies 2 cycles; cmd_ready is 0 in SWAP2. A following command is accepted no earlier than the cycle after SWAP2.
- Reset asserted during SWAP2: abort immediately. The second write does not occur; state IDLE, depth 0.
- depth, empty and full update at the accept edge.
- Error flags rise at the edge ending the erroring accept cycle.

## Test plan
- After reset, PUSH 0x11, 0x22, 0x33 on consecutive cycles: depth=3, top_data=0x33, second_data=0x22, cmd_ready high throughout.
- Push 8 values 0x01..0x08, then PUSH 0x99: err_overflow=1, depth=8, top_data=0x08, slot 0 still 0x01. CLEAR gives depth=0 and err_overflow=0.
- Stack [0x22, 0x33(top)], SWAP: cmd_ready=0 for exactly one cycle; afterwards top_data=0x22, second_data=0x33, depth=2.
- Stack [0x05, 0x07], BINOP with alu_result driven to 0x0C: depth=1, top_data=0x0C. Then POP: depth=0, empty=1. Then POP: err_underflow=1, depth stays 0, rf_wr_en never asserted.
- Stack [0xAA], DUP then OVER: depth=3, slots hold 0xAA, 0xAA, 0xAA. SWAP with depth=1 gives err_underflow=1 and no state change.
- Start SWAP with depth=2, assert reset mid-cycle in SWAP2: no write in SWAP2, depth=0, cmd_ready=1, flags 0. A fresh PUSH 0x44 gives top_data=0x44.

Source files
------------

// File: rtl/reg_stack_ctrl.sv
// Operand-stack controller: runs an external 8x8 register file as an 8-deep LIFO.
// It executes one command per handshake. SWAP takes two cycles: two writes through the single write port.
module reg_stack_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [7:0] alu_result,
  output logic [7:0] top_data,
  output logic [7:0] second_data,
  output logic [3:0] depth,
  output logic       empty,
  output logic       full,
  output logic       err_overflow,
  output logic       err_underflow,
  output logic [2:0] rf_re_sel_a,
  output logic [2:0] rf_re_sel_b,
  input  logic [7:0] rf_re_data_a,
  input  logic [7:0] rf_re_data_b,
  output logic [2:0] rf_wr_sel,
  output logic [7:0] rf_wr_data,
  output logic       rf_wr_en
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_BINOP = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic {IDLE, SWAP2} state_t;

  state_t     state, state_nxt;
  logic [7:0] hold;
  logic [2:0] top_sel, sec_sel, push_sel;
  logic       accept, underflow, overflow, exec;

  assign top_sel  = depth[2:0] - 3'd1;
  assign sec_sel  = depth[2:0] - 3'd2;
  assign push_sel = depth[2:0];

  assign rf_re_sel_a = top_sel;
  assign rf_re_sel_b = sec_sel;
  assign top_data    = rf_re_data_a;
  assign second_data = rf_re_data_b;
  assign empty       = (depth == 4'd0);
  assign full        = (depth == 4'd8);

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    case (cmd_op)
      OP_POP:                     underflow = (depth == 4'd0);
      OP_DUP: begin
        underflow = (depth == 4'd0);
        overflow  = full;
      end
      OP_SWAP, OP_BINOP:          underflow = (depth < 4'd2);
      OP_OVER: begin
        underflow = (depth < 4'd2);
        overflow  = full;
      end
      OP_PUSH:                    overflow  = full;
      default: ;
    endcase
  end

  // An erroring command is consumed without side effects other than its flag.
  assign exec = accept && !underflow && !overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (exec && cmd_op == OP_SWAP) state_nxt = SWAP2;
      SWAP2:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == IDLE);
    rf_wr_en   = 1'b0;
    rf_wr_sel  = push_sel;
    rf_wr_data = cmd_data;
    case (state)
      IDLE: if (exec) begin
        case (cmd_op)
          OP_PUSH: rf_wr_en = 1'b1;
          OP_DUP: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = rf_re_data_a;
          end
          OP_OVER: begin
            rf_wr_en   = 1'b1;
            rf_wr_data = rf_re_data_b;
          end
          OP_BINOP: begin
            rf_wr_en   = 1'b1;
            rf_wr_sel  = sec_sel;
            rf_wr_data = alu_result;
          end
          OP_SWAP: begin
            rf_wr_en   = 1'b1;
            rf_wr_sel  = sec_sel;
            rf_wr_data = rf_re_data_a;
          end
          default: ;
        endcase
      end
      SWAP2: begin
        rf_wr_en   = 1'b1;
        rf_wr_sel  = top_sel;
        rf_wr_data = hold;
      end
      default: ;
    endcase
    // Reset aborts a pending SWAP write immediately, not at the next edge.
    if (reset) rf_wr_en = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      depth <= 4'd0;
    end else if (exec) begin
      case (cmd_op)
        OP_PUSH, OP_DUP, OP_OVER: depth <= depth + 4'd1;
        OP_POP, OP_BINOP:         depth <= depth - 4'd1;
        OP_CLEAR:                 depth <= 4'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          hold <= 8'd0;
    else if (exec && cmd_op == OP_SWAP) hold <= rf_re_data_b;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (accept) begin
      if (cmd_op == OP_CLEAR) begin
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
      end else if (underflow) begin
        err_underflow <= 1'b1;
      end else if (overflow) begin
        err_overflow  <= 1'b1;
      end
    end
  end

endmodule
